locked_cmp_seq: RTL and testbench
=================================

LOCKED_CMP_SEQ -- requirements
Module: locked_cmp_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: compared data/key width, power of two, 2..256.
REQ-002 The block SHALL have parameter MAX_FAIL, default 3: consecutive mismatches before lockout, 1..255.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port key_load, input, 1 bit: serial key load enable.
REQ-006 The block SHALL have port key_bit, input, 1 bit: serial key data, MSB first.
REQ-007 The block SHALL have port key_valid, output, 1 bit: full key loaded and block usable.
REQ-008 The block SHALL have port mode, input, 1 bit: 0 = equality, 1 = inequality; sampled with each accepted input.
REQ-009 The block SHALL have ports in_valid (input, 1 bit), in_ready (output, 1 bit) and in_data (input, WIDTH bits): input handshake.
REQ-010 The block SHALL have ports out_valid (output, 1 bit), out_ready (input, 1 bit) and out_match (output, 1 bit): result handshake.
REQ-011 The block SHALL have port locked, output, 1 bit: sticky lockout flag.

Function
REQ-012 Input transfer SHALL occur when in_valid && in_ready; output transfer SHALL occur when out_valid && out_ready.
REQ-013 in_ready SHALL be key_valid && !locked && !key_load && !stall, where stall = out_valid && !out_ready.
REQ-014 Key load: each cycle key_load=1, key <= {key[WIDTH-2:0], key_bit}, bit counter increments and saturates at WIDTH.
REQ-015 Rising edge of key_load (first cycle high) SHALL clear key_valid, locked and fail_cnt, flush all pipeline valid bits and zero the bit counter before shifting.
REQ-016 key_valid SHALL assert in the first cycle key_load=0 with bit counter = WIDTH; a load shorter than WIDTH bits leaves key_valid=0.
REQ-017 Stage 0 SHALL register bitwise XNOR(in_data, key) and mode.
REQ-018 LEVELS = log2(WIDTH) stages SHALL follow, each a registered pairwise AND halving the vector.
REQ-019 out_match SHALL be (AND-reduce result) XOR mode, forced 0 when locked=1.
REQ-020 Latency SHALL be LEVELS+1 cycles from input transfer to out_valid without stall; throughput one result per cycle.
REQ-021 While stall=1 all pipeline stages SHALL hold; no result SHALL be dropped or duplicated.
REQ-022 On each output transfer: match=1 clears fail_cnt; match=0 increments fail_cnt, saturating at MAX_FAIL.
REQ-023 locked SHALL set in the cycle after fail_cnt reaches MAX_FAIL and clear only on key_load rising edge or reset.
REQ-024 In-flight results SHALL drain after lockout, with out_match=0.
REQ-025 When key_load and in_valid are both high, no input SHALL be accepted.

Reset
REQ-026 With rst_n=0 at a clock edge: key = 0, bit counter = 0, fail_cnt = 0, all valid bits = 0.
REQ-027 Reset outputs SHALL be key_valid=0, in_ready=0, out_valid=0, out_match=0, locked=0.
REQ-028 Reset mid-operation SHALL discard all in-flight results.

Structure
REQ-029 Package locked_cmp_pkg SHALL hold the mode enum (CMP_EQ, CMP_NE) and the LEVELS/counter-width constant functions.
REQ-030 Sub-module locked_cmp_stage SHALL implement one stall-able reduction level (valid, data, mode), instantiated LEVELS times via generate.

Verification (WIDTH=16, MAX_FAIL=3, latency 5)
REQ-031 Load key 16'hA5C3 serially, then in_data=16'hA5C3, mode=0 -> out_valid 5 cycles later, out_match=1, fail_cnt=0.
REQ-032 Back-to-back inputs 16'hA5C3, 16'hA5C2, 16'hA5C3 with mode=1 -> out_match 0, 1, 0 on three consecutive cycles.
REQ-033 Three mismatches 16'h0000 with mode=0 -> locked=1, in_ready=0; reload key -> locked=0, key_valid=1 after 16 bits.
REQ-034 Hold out_ready=0 for 4 cycles with 3 results in flight -> out_valid held, then results appear in order, none lost.
REQ-035 Assert rst_n=0 with 2 results in flight -> next cycle out_valid=0, key_valid=0; load 8 bits only -> key_valid stays 0.

Source files
------------

// File: rtl/locked_cmp_pkg.sv
// rtl/locked_cmp_pkg.sv - shared mode type and sizing helpers for the locked comparator
package locked_cmp_pkg;

    typedef enum logic {
        CMP_EQ = 1'b0,
        CMP_NE = 1'b1
    } cmp_mode_e;

    function automatic int levels_f(input int width);
        return $clog2(width);
    endfunction

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int cnt_width_f(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/locked_cmp_stage.sv
// rtl/locked_cmp_stage.sv - one stall-able pairwise-AND reduction level
module locked_cmp_stage
    import locked_cmp_pkg::*;
#(
    parameter int IN_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                en,
    input  logic                in_valid,
    input  logic [IN_W-1:0]     in_data,
    input  cmp_mode_e           in_mode,
    output logic                out_valid,
    output logic [IN_W/2-1:0]   out_data,
    output cmp_mode_e           out_mode
);

    localparam int OUT_W = IN_W / 2;

    logic             valid_q, valid_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic [OUT_W-1:0] pair_and;
    cmp_mode_e        mode_q, mode_d;

    always_comb begin
        pair_and = '0;
        for (int i = 0; i < OUT_W; i++) begin
            pair_and[i] = in_data[2*i] & in_data[2*i+1];
        end
    end

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        mode_d  = mode_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (en) begin
            valid_d = in_valid;
            data_d  = pair_and;
            mode_d  = in_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            mode_q  <= CMP_EQ;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_mode  = mode_q;

endmodule

// File: rtl/locked_cmp_seq.sv
// rtl/locked_cmp_seq.sv - serially keyed pipelined comparator with mismatch lockout
module locked_cmp_seq
    import locked_cmp_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int MAX_FAIL = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_load,
    input  logic             key_bit,
    output logic             key_valid,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_match,
    output logic             locked
);

    localparam int LEVELS   = levels_f(WIDTH);
    localparam int BCW      = cnt_width_f(WIDTH);
    localparam int FCW      = cnt_width_f(MAX_FAIL);
    localparam int LVL_BITS = 2 * WIDTH - 1;

    logic [WIDTH-1:0] key_q, key_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FCW-1:0]   fail_cnt_q, fail_cnt_d;
    logic             locked_q, locked_d;
    logic             key_load_q, key_load_d;
    logic             v0_q, v0_d;
    logic [WIDTH-1:0] xnor_q, xnor_d;
    cmp_mode_e        mode0_q, mode0_d;

    logic key_rise, key_full, stall, in_fire, out_fire;

    // All reduction levels packed back to back: level k holds WIDTH>>k bits
    // starting at bit 2*(WIDTH - (WIDTH>>k)); the final single bit is the MSB.
    logic [LVL_BITS-1:0] lvl_data;
    logic [LEVELS:0]     lvl_valid;
    cmp_mode_e           lvl_mode [LEVELS+1];

    assign key_rise  = key_load & ~key_load_q;
    assign key_full  = (bit_cnt_q == BCW'(WIDTH));
    assign key_valid = key_full & ~key_load;
    assign stall     = out_valid & ~out_ready;
    assign in_ready  = key_valid & ~locked_q & ~key_load & ~stall;
    assign in_fire   = in_valid & in_ready;
    assign out_valid = lvl_valid[LEVELS];
    assign out_fire  = out_valid & out_ready;
    assign out_match = ~locked_q & (lvl_data[LVL_BITS-1] ^ (lvl_mode[LEVELS] == CMP_NE));
    assign locked    = locked_q;

    always_comb begin
        key_d      = key_q;
        bit_cnt_d  = bit_cnt_q;
        key_load_d = key_load;
        if (key_load) begin
            key_d = {key_q[WIDTH-2:0], key_bit};
            if (key_rise) begin
                bit_cnt_d = BCW'(1);
            end else if (!key_full) begin
                bit_cnt_d = bit_cnt_q + BCW'(1);
            end
        end
    end

    // Lock follows the saturated fail count by one cycle; only a new key clears it.
    always_comb begin
        fail_cnt_d = fail_cnt_q;
        locked_d   = locked_q;
        if (key_rise) begin
            fail_cnt_d = '0;
            locked_d   = 1'b0;
        end else begin
            if (fail_cnt_q == FCW'(MAX_FAIL)) begin
                locked_d = 1'b1;
            end
            if (out_fire) begin
                if (out_match) begin
                    fail_cnt_d = '0;
                end else if (fail_cnt_q != FCW'(MAX_FAIL)) begin
                    fail_cnt_d = fail_cnt_q + FCW'(1);
                end
            end
        end
    end

    always_comb begin
        v0_d    = v0_q;
        xnor_d  = xnor_q;
        mode0_d = mode0_q;
        if (key_rise) begin
            v0_d = 1'b0;
        end else if (!stall) begin
            v0_d    = in_fire;
            xnor_d  = ~(in_data ^ key_q);
            mode0_d = cmp_mode_e'(mode);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_q      <= '0;
            bit_cnt_q  <= '0;
            fail_cnt_q <= '0;
            locked_q   <= 1'b0;
            key_load_q <= 1'b0;
            v0_q       <= 1'b0;
            xnor_q     <= '0;
            mode0_q    <= CMP_EQ;
        end else begin
            key_q      <= key_d;
            bit_cnt_q  <= bit_cnt_d;
            fail_cnt_q <= fail_cnt_d;
            locked_q   <= locked_d;
            key_load_q <= key_load_d;
            v0_q       <= v0_d;
            xnor_q     <= xnor_d;
            mode0_q    <= mode0_d;
        end
    end

    assign lvl_valid[0]         = v0_q;
    assign lvl_data[WIDTH-1:0]  = xnor_q;
    assign lvl_mode[0]          = mode0_q;

    for (genvar g = 0; g < LEVELS; g++) begin : g_lvl
        localparam int IN_W    = WIDTH >> g;
        localparam int IN_OFF  = 2 * (WIDTH - IN_W);
        localparam int OUT_OFF = 2 * (WIDTH - IN_W / 2);

        locked_cmp_stage #(
            .IN_W(IN_W)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (key_rise),
            .en        (~stall),
            .in_valid  (lvl_valid[g]),
            .in_data   (lvl_data[IN_OFF +: IN_W]),
            .in_mode   (lvl_mode[g]),
            .out_valid (lvl_valid[g+1]),
            .out_data  (lvl_data[OUT_OFF +: IN_W/2]),
            .out_mode  (lvl_mode[g+1])
        );
    end

endmodule

// File: tb/tb_locked_cmp_seq.sv
// tb/tb_locked_cmp_seq.sv - self-checking bench for locked_cmp_seq
module tb_locked_cmp_seq;

    localparam int WIDTH    = 16;
    localparam int MAX_FAIL = 3;
    localparam int LAT      = 5;

    logic             clk;
    logic             rst_n;
    logic             key_load;
    logic             key_bit;
    logic             key_valid;
    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_match;
    logic             locked;

    int checks = 0;
    int errors = 0;

    locked_cmp_seq #(
        .WIDTH    (WIDTH),
        .MAX_FAIL (MAX_FAIL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_load  (key_load),
        .key_bit   (key_bit),
        .key_valid (key_valid),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_match (out_match),
        .locked    (locked)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference model: in-flight results are queue entries with a countdown
    // to the output port; the whole queue freezes while the output stalls.
    typedef struct {
        bit raw;
        bit md;
        int cd;
    } item_t;

    item_t     m_pipe[$];
    bit [15:0] m_key;
    int        m_cnt;
    int        m_fail;
    bit        m_locked;
    bit        m_kl_prev;

    function automatic bit e_out_valid();
        return (m_pipe.size() > 0) && (m_pipe[0].cd == 0);
    endfunction

    function automatic bit e_out_match();
        if (!e_out_valid()) return 1'b0;
        return !m_locked && (m_pipe[0].raw ^ m_pipe[0].md);
    endfunction

    function automatic bit e_key_valid();
        return (m_cnt == WIDTH) && !key_load;
    endfunction

    function automatic bit e_in_ready();
        return e_key_valid() && !m_locked && !key_load && !(e_out_valid() && !out_ready);
    endfunction

    task automatic step();
        bit    ov, om, ir, stl, rise, nl;
        item_t it;
        @(posedge clk);
        if (!rst_n) begin
            m_key = '0; m_cnt = 0; m_fail = 0; m_locked = 0; m_kl_prev = 0;
            m_pipe.delete();
        end else begin
            ov   = e_out_valid();
            om   = e_out_match();
            ir   = e_in_ready();
            stl  = ov && !out_ready;
            rise = key_load && !m_kl_prev;
            if (rise) begin
                m_fail = 0;
                m_locked = 0;
                m_pipe.delete();
            end else begin
                nl = m_locked || (m_fail == MAX_FAIL);
                if (ov && out_ready) m_fail = om ? 0 : ((m_fail < MAX_FAIL) ? m_fail + 1 : m_fail);
                m_locked = nl;
                if (!stl) begin
                    if (ov) void'(m_pipe.pop_front());
                    for (int i = 0; i < m_pipe.size(); i++) m_pipe[i].cd = m_pipe[i].cd - 1;
                    if (in_valid && ir) begin
                        it.raw = (in_data == m_key);
                        it.md  = mode;
                        it.cd  = LAT - 1;
                        m_pipe.push_back(it);
                    end
                end
            end
            if (key_load) begin
                if (rise) m_cnt = 0;
                m_key = {m_key[14:0], key_bit};
                m_cnt = (m_cnt < WIDTH) ? m_cnt + 1 : WIDTH;
            end
            m_kl_prev = key_load;
        end
        #1;
    endtask

    task automatic load_key(input logic [15:0] k, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            key_load = 1'b1;
            key_bit  = k[15-i];
            step();
        end
        key_load = 1'b0;
        key_bit  = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; key_load = 1'b0; key_bit = 1'b0; mode = 1'b0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        step();
        step();
        checks++;
        if ({key_valid, in_ready, out_valid, out_match, locked} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got kv/ir/ov/om/lk=%b want 00000",
                     {key_valid, in_ready, out_valid, out_match, locked});
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if ({key_valid, in_ready, out_valid, locked} !== 4'b0) begin
            errors++;
            $display("FAIL reset_release: got kv/ir/ov/lk=%b want 0000",
                     {key_valid, in_ready, out_valid, locked});
        end
    endtask

    task automatic test_key_load();
        load_key(16'hA5C3, 15);
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL short_load_15: key_valid=%b want 0", key_valid);
        end
        load_key(16'hA5C3, 16);
        checks++;
        if (key_valid !== 1'b1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL full_load: key_valid=%b in_ready=%b want 1 1", key_valid, in_ready);
        end
    endtask

    task automatic test_match();
        int lat;
        out_ready = 1'b1; mode = 1'b0; in_valid = 1'b1; in_data = 16'hA5C3;
        #1;
        step();
        in_valid = 1'b0;
        #1;
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        checks++;
        if (lat != LAT) begin
            errors++;
            $display("FAIL match_latency: got %0d cycles want %0d", lat, LAT);
        end
        checks++;
        if (out_valid !== 1'b1 || out_match !== 1'b1) begin
            errors++;
            $display("FAIL match_eq: out_valid=%b out_match=%b want 1 1", out_valid, out_match);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int n;
        int exp_m[3] = '{0, 1, 0};
        logic [15:0] seq[3] = '{16'hA5C3, 16'hA5C2, 16'hA5C3};
        out_ready = 1'b1; mode = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = seq[k];
            step();
        end
        in_valid = 1'b0; mode = 1'b0;
        #1;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_match !== exp_m[k][0]) begin
                errors++;
                $display("FAIL b2b_result%0d: out_valid=%b out_match=%b want 1 %0d",
                         k, out_valid, out_match, exp_m[k]);
            end
            step();
        end
    endtask

    task automatic test_stall();
        int n;
        int exp_m[3] = '{1, 0, 0};
        logic [15:0] seq[3] = '{16'hA5C3, 16'h1234, 16'hA5C3};
        logic        mds[3] = '{1'b0, 1'b0, 1'b1};
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = seq[k];
            mode     = mds[k];
            step();
        end
        in_valid = 1'b0;
        #1;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_match !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: ov=%b om=%b ir=%b want 1 1 0",
                         c, out_valid, out_match, in_ready);
            end
            step();
        end
        out_ready = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_match !== exp_m[k][0]) begin
                errors++;
                $display("FAIL stall_drain%0d: ov=%b om=%b want 1 %0d", k, out_valid, out_match, exp_m[k]);
            end
            step();
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_no_dup: out_valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_lockout();
        int  got_n, got_ones;
        bit  seen;
        logic [15:0] k = 16'hA5C3;
        load_key(k, 16);
        out_ready = 1'b1; mode = 1'b0;
        for (int c = 0; c < 5; c++) begin
            in_valid = (c != 3);
            in_data  = (c == 4) ? k : 16'h0000;
            step();
        end
        in_valid = 1'b0;
        #1;
        got_n = 0; got_ones = 0;
        for (int c = 0; c < 12; c++) begin
            if (out_valid) begin
                got_n++;
                if (out_match) got_ones++;
            end
            step();
        end
        checks++;
        if (got_n != 4 || got_ones != 0) begin
            errors++;
            $display("FAIL lock_drain: results=%0d matches=%0d want 4 0", got_n, got_ones);
        end
        in_valid = 1'b1; in_data = k;
        #1;
        checks++;
        if (locked !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL lock_set: locked=%b in_ready=%b want 1 0", locked, in_ready);
        end
        key_load = 1'b1; key_bit = k[15];
        step();
        checks++;
        if (locked !== 1'b0 || in_ready !== 1'b0 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL reload_clear: locked=%b in_ready=%b key_valid=%b want 0 0 0",
                     locked, in_ready, key_valid);
        end
        for (int i = 14; i >= 0; i--) begin
            key_bit = k[i];
            step();
        end
        key_load = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (key_valid !== 1'b1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL reload_done: key_valid=%b locked=%b want 1 0", key_valid, locked);
        end
        seen = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL load_blocks_input: out_valid seen=%b want 0", seen);
        end
    endtask

    task automatic test_reset_midflight();
        bit seen;
        out_ready = 1'b1; mode = 1'b0; in_valid = 1'b1; in_data = 16'hA5C3;
        step();
        step();
        in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b0 || key_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset: out_valid=%b key_valid=%b want 0 0", out_valid, key_valid);
        end
        rst_n = 1'b1;
        #1;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL midreset_discard: out_valid seen=%b want 0", seen);
        end
        load_key(16'hA5C3, 8);
        step();
        step();
        checks++;
        if (key_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL short_load_8: key_valid=%b in_ready=%b want 0 0", key_valid, in_ready);
        end
    endtask

    task automatic test_random();
        int kl_left;
        int sel;
        load_key(16'($urandom), 16);
        kl_left = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (kl_left > 0) begin
                key_load = 1'b1;
                key_bit  = 1'($urandom_range(0, 1));
                kl_left--;
            end else begin
                key_load = 1'b0;
                if ($urandom_range(0, 99) < 2) kl_left = $urandom_range(10, 20);
            end
            in_valid  = ($urandom_range(0, 99) < 70);
            out_ready = ($urandom_range(0, 99) < 75);
            mode      = 1'($urandom_range(0, 1));
            sel       = $urandom_range(0, 3);
            if (sel < 2)       in_data = m_key;
            else if (sel == 2) in_data = m_key ^ (16'h1 << $urandom_range(0, 15));
            else               in_data = 16'($urandom);
            #1;
            checks++;
            if (in_ready !== e_in_ready() || key_valid !== e_key_valid()) begin
                errors++;
                $display("FAIL rand_ready cyc %0d: in_ready=%b key_valid=%b want %b %b",
                         cyc, in_ready, key_valid, e_in_ready(), e_key_valid());
            end
            checks++;
            if (out_valid !== e_out_valid() || locked !== m_locked) begin
                errors++;
                $display("FAIL rand_status cyc %0d: out_valid=%b locked=%b want %b %b",
                         cyc, out_valid, locked, e_out_valid(), m_locked);
            end
            if (e_out_valid()) begin
                checks++;
                if (out_match !== e_out_match()) begin
                    errors++;
                    $display("FAIL rand_match cyc %0d: out_match=%b want %b", cyc, out_match, e_out_match());
                end
            end
            step();
        end
        key_load = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_key_load();
        test_match();
        test_back_to_back();
        test_stall();
        test_lockout();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
